sha256_host_ctrl: RTL and testbench
===================================

SHA256_HOST_CTRL -- requirements
Module: sha256_host_ctrl

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 127: max cycles in WAIT before timeout.
REQ-002 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  in  1  begin one block; sampled only in IDLE.
REQ-005 SHALL have port msg_valid  in  1  upstream message word valid.
REQ-006 SHALL have port msg_data  in  32  upstream message word (pre-padded block, W0 first).
REQ-007 SHALL have port msg_ready  out  1  word accepted when msg_valid & msg_ready.
REQ-008 SHALL have port core_soc  out  1  start-of-conversion to SHA256 core.
REQ-009 SHALL have port core_rd  out  1  hash read request to core.
REQ-010 SHALL have port core_eoc  in  1  end-of-conversion from core.
REQ-011 SHALL have port bus_out  out  32  word driven toward the core's data bus.
REQ-012 SHALL have port bus_oe  out  1  tristate enable for bus_out (merged at top level).
REQ-013 SHALL have port bus_in  in  32  core data bus as read back.
REQ-014 SHALL have port digest  out  256  captured hash, H0 in [255:224], H7 in [31:0].
REQ-015 SHALL have port digest_valid  out  1  one-cycle pulse on completion.
REQ-016 SHALL have port busy  out  1  high in any state except IDLE.
REQ-017 SHALL have port err  out  1  sticky timeout flag.

Function
REQ-018 SHALL implement states IDLE, FILL, SOC, LOAD, WAIT, READ, DONE, ERR.
REQ-019 IDLE: start=1 -> FILL, clears err and the word index; start ignored in all other states.
REQ-020 FILL: msg_ready=1; each handshake writes msg_data into a 16x32 buffer at the index, index+1; after the 16th accept -> SOC; gaps in msg_valid stall without loss.
REQ-021 SOC: core_soc=1 for exactly one cycle, bus_oe=0 -> LOAD, index cleared.
REQ-022 LOAD: bus_oe=1, bus_out=buffer[i] on the i-th LOAD cycle, i=0..15, one word per cycle with no stalls; after 16 cycles -> WAIT with bus_oe=0.
REQ-023 WAIT: a cycle counter counts from 0; core_eoc=1 -> READ; counter reaching WAIT_LIMIT with core_eoc=0 -> ERR.
REQ-024 READ: core_rd=1 for exactly 8 cycles, bus_oe=0; on each rising edge with core_rd & core_eoc the next word j=0..7 is captured from bus_in into digest word Hj; then -> DONE.
REQ-025 READ with core_eoc dropping: capture pauses, core_rd stays high, j holds, and the WAIT counter governs timeout again.
REQ-026 DONE: digest_valid=1 for one cycle -> IDLE; digest holds until the next READ capture.
REQ-027 ERR: err=1 and stays 1; -> IDLE next cycle; digest unchanged, digest_valid never pulses.
REQ-028 bus_oe and core_rd SHALL never be 1 in the same cycle, and bus_oe SHALL be 0 outside LOAD.
REQ-029 Counters SHALL be 4-bit (word index), 3-bit (hash index), and 8-bit (WAIT), with no wrap beyond the stated limits.

Reset
REQ-030 rst=1 SHALL immediately force IDLE, with msg_ready=0, core_soc=0, core_rd=0, bus_oe=0, bus_out=0, digest=0, digest_valid=0, busy=0, err=0, and all indices 0.
REQ-031 Reset mid-FILL, LOAD, or READ SHALL abandon the block; after release, start begins a fresh block and no partial buffer contents are reused.

Structure
REQ-032 A shared package SHALL hold the state enumeration, block length 16, digest length 8, and default WAIT_LIMIT.
REQ-033 The 16x32 message buffer SHALL be one sub-module, msg_buf16, with write-port and read-index interfaces.

Verification
REQ-034 "abc" padded block (61626380, 0 x14, 00000018) loaded via a real SHA256 core -> digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, with one digest_valid pulse.
REQ-035 msg_valid toggled randomly during FILL -> identical LOAD sequence and digest as REQ-034; core_soc pulses exactly once.
REQ-036 Core model that never raises core_eoc -> err=1 at WAIT entry + WAIT_LIMIT cycles, busy=0 next cycle, and no digest_valid.
REQ-037 rst pulsed during LOAD word 7 -> all outputs at reset values within the same cycle, and the next full block yields the correct digest.
REQ-038 start held high throughout a block -> exactly one block processed per IDLE visit, with no overlap.
REQ-039 An assertion SHALL check every cycle that !(bus_oe & core_rd) and that core_soc is only ever a one-cycle pulse.

Source files
------------

// File: rtl/sha256_host_ctrl_pkg.sv
// Shared types and sizing for the SHA-256 host controller.
package sha256_host_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_SOC, S_LOAD, S_WAIT, S_READ, S_DONE, S_ERR
  } state_t;

  localparam int BLK_WORDS      = 16;   // 32-bit words per message block
  localparam int DIG_WORDS      = 8;    // 32-bit words per digest
  localparam int WAIT_LIMIT_DEF = 127;  // default cycles allowed without core_eoc

endpackage

// File: rtl/sha256_host_ctrl_if.sv
// Message-upstream and core-side bus signals of the host controller.
// master = controller side, slave = message source / core side.
interface sha256_host_ctrl_if;
  logic        msg_valid;
  logic [31:0] msg_data;
  logic        msg_ready;
  logic        core_soc;
  logic        core_rd;
  logic        core_eoc;
  logic [31:0] bus_out;
  logic        bus_oe;
  logic [31:0] bus_in;

  modport master (
    input  msg_valid, msg_data, core_eoc, bus_in,
    output msg_ready, core_soc, core_rd, bus_out, bus_oe
  );

  modport slave (
    output msg_valid, msg_data, core_eoc, bus_in,
    input  msg_ready, core_soc, core_rd, bus_out, bus_oe
  );
endinterface

// File: rtl/sha256_host_ctrl_msg_buf16.sv
// 16x32 message block buffer: one synchronous write port, one async read index.
module msg_buf16
  import sha256_host_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        wr_en,
  input  logic [3:0]  wr_idx,
  input  logic [31:0] wr_data,
  input  logic [3:0]  rd_idx,
  output logic [31:0] rd_data
);

  logic [31:0] mem [BLK_WORDS];

  // Contents need no reset: every block is fully rewritten before it is read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/sha256_host_ctrl.sv
// Host-side sequencer for a SHA-256 core: buffers one 16-word block, loads it
// onto the core bus, waits for end-of-conversion and reads back the digest.
module sha256_host_ctrl
  import sha256_host_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = WAIT_LIMIT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  sha256_host_ctrl_if.master host,
  output logic [255:0]       digest,
  output logic               digest_valid,
  output logic               busy,
  output logic               err
);

  localparam logic [3:0] IDX_LAST  = 4'(BLK_WORDS - 1);
  localparam logic [2:0] HIDX_LAST = 3'(DIG_WORDS - 1);
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

  state_t      state, nstate;
  logic [3:0]  idx;    // message word index (FILL write, LOAD read)
  logic [2:0]  hidx;   // digest word index
  logic [7:0]  wcnt;   // cycles without core_eoc
  logic [31:0] rd_word;
  logic        buf_we;

  assign buf_we = (state == S_FILL) && host.msg_valid;

  msg_buf16 u_buf (
    .clk     (clk),
    .wr_en   (buf_we),
    .wr_idx  (idx),
    .wr_data (host.msg_data),
    .rd_idx  (idx),
    .rd_data (rd_word)
  );

  assign busy         = (state != S_IDLE);
  assign host.bus_out = host.bus_oe ? rd_word : '0;

  // State register; reset lands in IDLE without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nstate;
  end

  // Next-state and Moore outputs decoded from the current state.
  always_comb begin
    nstate         = state;
    host.msg_ready = 1'b0;
    host.core_soc  = 1'b0;
    host.core_rd   = 1'b0;
    host.bus_oe    = 1'b0;
    digest_valid   = 1'b0;
    case (state)
      S_IDLE: if (start) nstate = S_FILL;
      S_FILL: begin
        host.msg_ready = 1'b1;
        if (host.msg_valid && idx == IDX_LAST) nstate = S_SOC;
      end
      S_SOC: begin
        host.core_soc = 1'b1;
        nstate        = S_LOAD;
      end
      S_LOAD: begin
        host.bus_oe = 1'b1;
        if (idx == IDX_LAST) nstate = S_WAIT;
      end
      S_WAIT: begin
        if (host.core_eoc)           nstate = S_READ;
        else if (wcnt == WAIT_LAST)  nstate = S_ERR;
      end
      S_READ: begin
        host.core_rd = 1'b1;
        if (host.core_eoc) begin
          if (hidx == HIDX_LAST) nstate = S_DONE;
        end else if (wcnt == WAIT_LAST) begin
          nstate = S_ERR;
        end
      end
      S_DONE: begin
        digest_valid = 1'b1;
        nstate       = S_IDLE;
      end
      S_ERR:   nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  // Indices, timeout counter, digest capture and the sticky error flag.
  // The timeout counter restarts on every captured word, so in READ it
  // bounds the length of a single core_eoc gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= '0;
      hidx   <= '0;
      wcnt   <= '0;
      digest <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          idx <= '0;
          err <= 1'b0;
        end
        S_FILL: if (host.msg_valid) idx <= idx + 4'd1;
        S_SOC: begin
          idx  <= '0;
          hidx <= '0;
        end
        S_LOAD: begin
          idx  <= idx + 4'd1;
          wcnt <= '0;
        end
        S_WAIT: begin
          if (host.core_eoc) begin
            wcnt <= '0;
            hidx <= '0;
          end else if (wcnt == WAIT_LAST) begin
            err  <= 1'b1;
          end else begin
            wcnt <= wcnt + 8'd1;
          end
        end
        S_READ: begin
          if (host.core_eoc) begin
            digest[{~hidx, 5'd0} +: 32] <= host.bus_in;
            hidx <= hidx + 3'd1;
            wcnt <= '0;
          end else if (wcnt == WAIT_LAST) begin
            err  <= 1'b1;
          end else begin
            wcnt <= wcnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_host_ctrl.sv
// Scoreboard bench: stimulus queues expected load words and digests; a
// monitor pops and compares as the DUT presents them. A behavioural SHA-256
// core model sits on the bus and hashes whatever block it is loaded with.
module tb_sha256_host_ctrl;

  localparam int WL = 127;

  typedef logic [31:0] blk_t [16];

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [255:0] digest;
  logic         digest_valid, busy, err;

  sha256_host_ctrl_if bus_if ();

  sha256_host_ctrl #(.WAIT_LIMIT(WL)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .host         (bus_if),
    .digest       (digest),
    .digest_valid (digest_valid),
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int soc_cnt = 0, dv_cnt = 0;
  logic [31:0]  msg_q [$];
  logic [31:0]  load_q [$];
  logic [255:0] exp_q [$];
  bit gaps = 0, stall = 0, hang = 0;
  int lat = 4;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // One SHA-256 compression of a pre-padded block from the standard IV.
  function automatic logic [255:0] sha256_blk(input blk_t m);
    logic [31:0] w [64];
    logic [31:0] r [8];
    logic [31:0] t1, t2, s0, s1;
    logic [255:0] res;
    for (int i = 0; i < 16; i++) w[i] = m[i];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
    for (int i = 0; i < 8; i++) r[i] = IV[i];
    for (int i = 0; i < 64; i++) begin
      t1 = r[7] + (rotr(r[4], 6) ^ rotr(r[4], 11) ^ rotr(r[4], 25))
           + ((r[4] & r[5]) ^ (~r[4] & r[6])) + K[i] + w[i];
      t2 = (rotr(r[0], 2) ^ rotr(r[0], 13) ^ rotr(r[0], 22))
           + ((r[0] & r[1]) ^ (r[0] & r[2]) ^ (r[1] & r[2]));
      for (int j = 7; j > 0; j--) r[j] = r[j-1];
      r[4] = r[4] + t1;
      r[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = r[i] + IV[i];
    return res;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // Upstream message source: offers queued words, optionally with random gaps.
  initial begin : feeder
    bit acc;
    bus_if.msg_valid = 1'b0;
    bus_if.msg_data  = '0;
    forever begin
      @(negedge clk);
      acc = bus_if.msg_valid && bus_if.msg_ready && !rst;
      @(posedge clk); #1;
      if (acc) void'(msg_q.pop_front());
      if (msg_q.size() > 0 && (!gaps || $urandom_range(1) == 1)) begin
        bus_if.msg_valid = 1'b1;
        bus_if.msg_data  = msg_q[0];
      end else begin
        bus_if.msg_valid = 1'b0;
        bus_if.msg_data  = $urandom;
      end
    end
  end

  // Behavioural SHA-256 core: collects 16 words after soc, hashes them,
  // raises eoc after a latency and streams H0..H7 on each rd & eoc edge.
  initial begin : core_model
    blk_t m;
    logic [255:0] h;
    int n, cnt, rptr;
    bit ready, soc_s, oe_s, rd_s, eoc_s;
    logic [31:0] w_s;
    n = 16; cnt = -1; rptr = 0; ready = 0; h = '0;
    bus_if.core_eoc = 1'b0;
    bus_if.bus_in   = '0;
    forever begin
      @(negedge clk);
      soc_s = bus_if.core_soc; oe_s = bus_if.bus_oe; w_s = bus_if.bus_out;
      rd_s  = bus_if.core_rd;  eoc_s = bus_if.core_eoc;
      @(posedge clk); #1;
      if (soc_s) begin
        soc_cnt++; n = 0; ready = 0; cnt = -1; bus_if.core_eoc = 1'b0;
      end
      if (cnt > 0) cnt--;
      else if (cnt == 0) begin ready = 1; rptr = 0; cnt = -1; end
      if (oe_s && n < 16) begin
        m[n] = w_s; n++;
        if (n == 16) begin h = sha256_blk(m); cnt = hang ? -1 : lat; end
      end
      if (ready) begin
        if (rd_s && eoc_s) rptr++;
        if (rptr < 8) bus_if.bus_in = 32'(h >> (32 * (7 - rptr)));
        bus_if.core_eoc = !(stall && rptr < 8 && $urandom_range(3) == 0);
      end
    end
  end

  // Monitor: bus exclusivity/soc pulse properties every cycle, load-word
  // order against load_q, digest against exp_q on each digest_valid.
  initial begin : monitor
    bit prev_soc;
    logic [31:0] w;
    logic [255:0] e;
    prev_soc = 0;
    forever begin
      @(negedge clk);
      if (rst) prev_soc = 0;
      else begin
        checks++;
        assert (!(bus_if.bus_oe && bus_if.core_rd)) else begin
          failures++;
          $display("FAIL oe_rd_exclusive: bus_oe=%0b core_rd=%0b required not both 1", bus_if.bus_oe, bus_if.core_rd);
        end
        checks++;
        assert (!(prev_soc && bus_if.core_soc)) else begin
          failures++;
          $display("FAIL soc_pulse: core_soc high 2 cycles, required 1");
        end
        prev_soc = bus_if.core_soc;
        if (bus_if.bus_oe) begin
          if (load_q.size() == 0) chk("load_unexpected", 256'(bus_if.bus_out), 256'hx);
          else begin w = load_q.pop_front(); chk("load_word", 256'(bus_if.bus_out), 256'(w)); end
        end
        if (digest_valid) begin
          dv_cnt++;
          if (exp_q.size() == 0) chk("digest_unexpected", 256'(digest_valid), 256'd0);
          else begin e = exp_q.pop_front(); chk("digest", digest, e); end
        end
      end
    end
  end

  task automatic rnd_blk(output blk_t m);
    for (int i = 0; i < 16; i++) m[i] = $urandom;
  endtask

  task automatic issue(input blk_t m, input bit expect_done, input logic [255:0] exp);
    for (int i = 0; i < 16; i++) begin msg_q.push_back(m[i]); load_q.push_back(m[i]); end
    if (expect_done) exp_q.push_back(exp);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("err_cleared_by_start", 256'(err), 256'd0);
  endtask

  task automatic wait_done(input string nm, output bit seen);
    seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      seen = digest_valid;
    end
    chk(nm, 256'(seen), 256'd1);
  endtask

  task automatic complete(input string nm, input int s0, input int d0);
    bit seen;
    wait_done(nm, seen);
    @(negedge clk); @(negedge clk);
    chk("idle_after_done", 256'(busy), 256'd0);
    chk("one_digest_valid", 256'(dv_cnt - d0), 256'd1);
    chk("one_soc", 256'(soc_cnt - s0), 256'd1);
  endtask

  initial begin : stim
    blk_t abc, m, m2;
    logic [255:0] last_dig;
    int s0, d0, n, k;
    bit seen;
    for (int i = 0; i < 16; i++) abc[i] = '0;
    abc[0]  = 32'h61626380;
    abc[15] = 32'h00000018;
    start = 1'b0;
    rst   = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ctrl_outputs", 256'({bus_if.msg_ready, bus_if.core_soc, bus_if.core_rd, bus_if.bus_oe,
                                  digest_valid, busy, err}), 256'd0);
    chk("rst_bus_out", 256'(bus_if.bus_out), 256'd0);
    chk("rst_digest", digest, 256'd0);
    @(posedge clk); #1 rst = 1'b0;

    // "abc" with no upstream gaps, then with random gaps
    s0 = soc_cnt; d0 = dv_cnt;
    issue(abc, 1, ABC_DIGEST);
    complete("abc_done", s0, d0);
    gaps = 1; lat = 9;
    s0 = soc_cnt; d0 = dv_cnt;
    issue(abc, 1, ABC_DIGEST);
    complete("abc_gaps_done", s0, d0);

    // random blocks with gaps, random latency and eoc drops during READ
    stall = 1;
    for (int b = 0; b < 3; b++) begin
      rnd_blk(m);
      lat = $urandom_range(12, 1);
      s0 = soc_cnt; d0 = dv_cnt;
      last_dig = sha256_blk(m);
      issue(m, 1, last_dig);
      complete("rand_done", s0, d0);
    end
    stall = 0;

    // core never raises eoc: timeout exactly WL cycles after WAIT entry
    hang = 1;
    rnd_blk(m);
    d0 = dv_cnt;
    issue(m, 0, '0);
    n = 0;
    for (int i = 0; i < 500 && !bus_if.bus_oe; i++) @(negedge clk);
    for (int i = 0; i < 500 && bus_if.bus_oe; i++) @(negedge clk);
    k = 0;
    while (!err && k < 300) begin @(negedge clk); k++; end
    chk("timeout_cycle", 256'(k), 256'(WL));
    @(negedge clk);
    chk("idle_after_err", 256'(busy), 256'd0);
    chk("err_sticky", 256'(err), 256'd1);
    repeat (5) @(negedge clk);
    chk("no_dv_on_err", 256'(dv_cnt - d0), 256'd0);
    chk("digest_kept_on_err", digest, last_dig);
    hang = 0;
    lat = 3;

    // reset during LOAD word 7, then a fresh full block
    rnd_blk(m);
    issue(m, 0, '0);
    n = 0;
    for (int i = 0; i < 500 && n < 8; i++) begin
      @(negedge clk);
      if (bus_if.bus_oe) n++;
    end
    chk("reach_load_word7", 256'(n), 256'd8);
    #2 rst = 1'b1;
    #1;
    chk("midload_rst_ctrl", 256'({bus_if.msg_ready, bus_if.core_soc, bus_if.core_rd, bus_if.bus_oe,
                                  digest_valid, busy, err}), 256'd0);
    chk("midload_rst_bus_out", 256'(bus_if.bus_out), 256'd0);
    chk("midload_rst_digest", digest, 256'd0);
    @(posedge clk); #1 rst = 1'b0;
    load_q.delete();
    s0 = soc_cnt; d0 = dv_cnt;
    issue(abc, 1, ABC_DIGEST);
    complete("after_rst_done", s0, d0);

    // start held high across two blocks: one block per IDLE visit
    rnd_blk(m); rnd_blk(m2);
    for (int i = 0; i < 16; i++) begin msg_q.push_back(m[i]); load_q.push_back(m[i]); end
    for (int i = 0; i < 16; i++) begin msg_q.push_back(m2[i]); load_q.push_back(m2[i]); end
    exp_q.push_back(sha256_blk(m));
    exp_q.push_back(sha256_blk(m2));
    s0 = soc_cnt; d0 = dv_cnt;
    @(posedge clk); #1 start = 1'b1;
    wait_done("held_first_done", seen);
    @(posedge clk); #1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("held_second_done", seen);
    repeat (40) @(negedge clk);
    chk("held_dv_count", 256'(dv_cnt - d0), 256'd2);
    chk("held_soc_count", 256'(soc_cnt - s0), 256'd2);
    chk("held_idle_after", 256'(busy), 256'd0);
    chk("held_words_consumed", 256'(msg_q.size()), 256'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
